// File: rtl/mul_seq_ctrl_pkg.sv
// ============================================================================
// Module  : mul_seq_ctrl_pkg
// Purpose : Shared types and constants for the sequential multiply unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_seq_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Custom opcode decoded upstream into mul_start.
    localparam logic [6:0] MUL_OPCODE = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
// ============================================================================
// Module  : mul_shift_add_dp
// Purpose : Radix-2 shift-add accumulator producing a 2*XLEN unsigned product.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_shift_add_dp
    import mul_seq_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_capture,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_prod_hi,
    output logic [XLEN-1:0] o_prod_lo
);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_prod_hi;
    logic [XLEN-1:0] r_prod_lo;

    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    // The adder carry becomes the new MSB of hi as {carry, hi, lo} shifts right.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            if (i_load) begin
                r_a  <= i_op_a;
                r_hi <= '0;
                r_lo <= i_op_b;
            end else if (i_step) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
            if (i_capture) begin
                r_prod_hi <= w_hi_nxt;
                r_prod_lo <= w_lo_nxt;
            end
        end
    end

    assign o_prod_hi = r_prod_hi;
    assign o_prod_lo = r_prod_lo;

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module  : mul_seq_ctrl
// Purpose : Sequencer for a fixed-latency unsigned multiply with pipeline stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MUL_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_mul_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_prod_lo,
    output logic [XLEN-1:0] o_prod_hi
);

    localparam int            CW     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(MUL_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_load;
    logic          w_step;
    logic          w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // A start seen in DONE belongs to the retiring instruction, so only IDLE accepts.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mul_start && !i_flush) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stall is raised in the accepting cycle itself so the PC never advances past it.
    assign o_stall = rst_n & (w_load | (r_state == ST_BUSY));
    assign o_busy  = (r_state == ST_BUSY);
    assign o_done  = (r_state == ST_DONE);

    mul_shift_add_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_capture (w_capture),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .o_prod_hi (o_prod_hi),
        .o_prod_lo (o_prod_lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module  : tb_mul_seq_ctrl
// Purpose : Self-checking bench for mul_seq_ctrl against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 32;

    logic            clk;
    logic            rst_n;
    logic            i_mul_start;
    logic            i_flush;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            o_stall;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_prod_lo;
    logic [XLEN-1:0] o_prod_hi;

    int n_cmp;
    int n_bad;

    // Behavioural model: cycles of iteration left, done flag, product registers.
    int          m_left;
    bit          m_done;
    logic [63:0] m_pend;
    logic [63:0] m_prod;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    mul_seq_ctrl #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mul_start (i_mul_start),
        .i_flush     (i_flush),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .o_stall     (o_stall),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_prod_lo   (o_prod_lo),
        .o_prod_hi   (o_prod_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [66:0] got, input logic [66:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_done = 0;
        m_prod = '0;
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the model.
    task automatic step(input logic s, input logic f, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
        logic [66:0] exp;
        bit          idle;
        @(negedge clk);
        i_mul_start = s;
        i_flush     = f;
        i_op_a      = a;
        i_op_b      = b;
        #1;
        idle = (m_left == 0) && !m_done;
        if (!rst_n) exp = '0;
        else exp = {(idle && s && !f) || (m_left > 0), m_left > 0, m_done, m_prod};
        check(nm, {o_stall, o_busy, o_done, o_prod_hi, o_prod_lo}, exp);
        if (!rst_n) begin
            model_reset();
        end else if (f) begin
            m_left = 0;
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_prod = m_pend;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (s) begin
            m_left = MUL_CYCLES;
            m_pend = 64'(a) * 64'(b);
        end
    endtask

    // Full transaction with start held; operands scrambled after acceptance.
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo);
        int n_stall;
        bit got_done;
        n_stall  = 0;
        got_done = 0;
        for (int c = 0; c < MUL_CYCLES + 8 && !got_done; c++) begin
            step(1'b1, 1'b0, (c == 0) ? a : $urandom, (c == 0) ? b : $urandom, "vec_cycle");
            if (o_stall) n_stall++;
            if (o_done) begin
                got_done = 1;
                check("vec_product", {3'b0, o_prod_hi, o_prod_lo}, {3'b0, hi, lo});
            end
        end
        check("vec_latency", 67'({got_done, 32'(n_stall)}), 67'({1'b1, 32'(MUL_CYCLES + 1)}));
        step(1'b0, 1'b0, '0, '0, "vec_release");
    endtask

    initial begin
        int n_done;
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        m_pend = '0;
        rst_n       = 1'b0;
        i_mul_start = 1'b0;
        i_flush     = 1'b0;
        i_op_a      = '0;
        i_op_b      = '0;

        vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'd15};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'd0,          32'h1234_5678,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'd7,          32'd9,          32'h0000_0000, 32'd63};
        vecs[4] = '{32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
        vecs[6] = '{32'h1234_5678,  32'd0,          32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};

        step(1'b1, 1'b0, 32'd3, 32'd5, "reset_hold");
        step(1'b0, 1'b0, '0, '0, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, '0, "after_reset");

        foreach (vecs[i]) run_vec(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Flush on BUSY cycle 10: previous product (1 * FFFFFFFF) must survive.
        step(1'b1, 1'b0, 32'd3, 32'd5, "flush_accept");
        for (int c = 1; c < 10; c++) step(1'b1, 1'b0, 32'd3, 32'd5, "flush_busy");
        step(1'b1, 1'b1, 32'd3, 32'd5, "flush_cycle");
        step(1'b0, 1'b0, '0, '0, "flush_after");
        check("flush_state", {o_stall, o_busy, o_done, o_prod_hi, o_prod_lo},
              {3'b000, 32'h0, 32'hFFFF_FFFF});

        // Start and flush together in IDLE: nothing is accepted.
        step(1'b1, 1'b1, 32'd3, 32'd5, "flush_wins");
        step(1'b0, 1'b0, '0, '0, "flush_wins_idle");
        check("flush_wins_busy", 67'(o_busy), 67'(0));

        // Asynchronous reset on BUSY cycle 5.
        step(1'b1, 1'b0, 32'd11, 32'd13, "rst_accept");
        for (int c = 1; c <= 5; c++) step(1'b1, 1'b0, 32'd11, 32'd13, "rst_busy");
        i_mul_start = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", {o_stall, o_busy, o_done, o_prod_hi, o_prod_lo}, '0);
        step(1'b0, 1'b0, '0, '0, "rst_low");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, '0, "rst_release");
        run_vec(32'd3, 32'd5, 32'd0, 32'd15);

        // Start held through DONE, dropped for one cycle, then a new 7*9.
        n_done = 0;
        for (int c = 0; c < MUL_CYCLES + 2; c++) begin
            step(1'b1, 1'b0, 32'd5, 32'd6, "hold_through_done");
            if (o_done) n_done++;
        end
        step(1'b0, 1'b0, '0, '0, "hold_gap");
        if (o_done) n_done++;
        check("hold_one_done", 67'(n_done), 67'(1));
        check("hold_first_prod", {3'b0, o_prod_hi, o_prod_lo}, {3'b0, 64'd30});
        run_vec(32'd7, 32'd9, 32'd0, 32'd63);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, ra, rb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
